// File: rtl/hack_boot_ctrl.sv
// hack_boot_ctrl: boot sequencer for the Hack SoC.
// Holds the CPU in reset and receives a length-prefixed byte stream:
// a 16-bit word count N (high byte first), then N 16-bit words (high byte
// first). Each word is written to instruction ROM from address 0 upward,
// then the CPU is released. A new load may be requested at any time.
`timescale 1ns/1ps

module hack_boot_ctrl #(
    parameter int WORD_WIDTH        = 16,
    parameter int ROM_ADDRESS_WIDTH = 15,
    parameter int ROM_WORDS         = 32768
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic                         run,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic                         rom_we,
    output logic [ROM_ADDRESS_WIDTH-1:0] rom_addr,
    output logic [WORD_WIDTH-1:0]        rom_wdata,
    output logic                         cpu_reset,
    output logic                         busy,
    output logic                         loaded,
    output logic                         error
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_LEN_LO  = 4'd2;
    localparam logic [3:0] S_DATA_HI = 4'd3;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_RELEASE = 4'd6;
    localparam logic [3:0] S_RUN     = 4'd7;
    localparam logic [3:0] S_ERROR   = 4'd8;

    // Largest accepted word count, one bit wider than the length field so
    // that the full-depth count 0x8000 compares cleanly.
    localparam logic [16:0] MAX_WORDS = 17'(ROM_WORDS);

    logic [3:0]                   state;
    logic [7:0]                   len_hi;
    logic [15:0]                  len;
    logic [7:0]                   data_hi;
    logic [15:0]                  word_cnt;
    logic [ROM_ADDRESS_WIDTH-1:0] addr_cnt;

    logic        xfer;
    logic [15:0] len_full;

    assign xfer     = byte_valid & byte_ready;
    assign len_full = {len_hi, byte_data};

    // Outputs decoded purely from the state register: no input reaches an
    // output without passing through a flop.
    // NOTE: continuous assigns of complete expressions cannot infer latches.
    assign cpu_reset  = (state != S_RUN);
    assign rom_we     = (state == S_WRITE);
    assign byte_ready = (state == S_LEN_HI)  || (state == S_LEN_LO) ||
                        (state == S_DATA_HI) || (state == S_DATA_LO);
    assign busy       = (state == S_LEN_HI)  || (state == S_LEN_LO)  ||
                        (state == S_DATA_HI) || (state == S_DATA_LO) ||
                        (state == S_WRITE)   || (state == S_RELEASE);

    // Sequencer: load_start overrides everything, otherwise step the stream.
    // NOTE: all state here uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            len_hi    <= '0;
            len       <= '0;
            data_hi   <= '0;
            word_cnt  <= '0;
            addr_cnt  <= '0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            loaded    <= 1'b0;
            error     <= 1'b0;
        end else if (load_start) begin
            // Restart: any byte presented this cycle is deliberately dropped.
            state    <= S_LEN_HI;
            word_cnt <= '0;
            addr_cnt <= '0;
            loaded   <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_RUN;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= byte_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len <= len_full;
                        if ({1'b0, len_full} > MAX_WORDS) begin
                            error <= 1'b1;
                            state <= S_ERROR;
                        end else if (len_full == 16'd0) begin
                            state <= S_RELEASE;
                        end else begin
                            word_cnt <= '0;
                            addr_cnt <= '0;
                            state    <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (xfer) begin
                        data_hi <= byte_data;
                        state   <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    // Present address and word for the WRITE cycle; they hold
                    // afterwards because nothing else loads them.
                    if (xfer) begin
                        rom_addr  <= addr_cnt;
                        rom_wdata <= WORD_WIDTH'({data_hi, byte_data});
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // The address counter may wrap after 0x7FFF; the word
                    // counter is wide enough that 0x8000 terminates the load.
                    word_cnt <= word_cnt + 16'd1;
                    addr_cnt <= addr_cnt + 1'b1;
                    if (word_cnt + 16'd1 == len) begin
                        state <= S_RELEASE;
                    end else begin
                        state <= S_DATA_HI;
                    end
                end
                S_RELEASE: begin
                    loaded <= 1'b1;
                    state  <= S_RUN;
                end
                S_RUN, S_ERROR: begin
                    state <= state;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// tb_hack_boot_ctrl: directed and randomized bench for hack_boot_ctrl.
// The reference model is transaction level: a load of N words is a byte
// list plus the list of (index, word) ROM writes it must produce, and the
// release latency with no stalls is 3N+4 cycles.
`timescale 1ns/1ps

module tb_hack_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        run;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        loaded;
    logic        error;

    hack_boot_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .run        (run),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .loaded     (loaded),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to measure latency.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: sampled 1 ns after each rising edge.
    logic [30:0] wr_q[$];
    always begin
        @(posedge clk);
        #1;
        if (rom_we === 1'b1) wr_q.push_back({rom_addr, rom_wdata});
    end

    logic [7:0]  stream_q[$];
    logic [30:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int t0;
    int at;
    int n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: a load of n random words -> byte stream and expected writes.
    task automatic make_load(input int nw);
        logic [15:0] len;
        logic [15:0] w;
        len = 16'(nw);
        stream_q.delete();
        exp_q.delete();
        stream_q.push_back(len[15:8]);
        stream_q.push_back(len[7:0]);
        for (int i = 0; i < nw; i++) begin
            w = 16'($urandom);
            stream_q.push_back(w[15:8]);
            stream_q.push_back(w[7:0]);
            exp_q.push_back({15'(i), w});
        end
    endtask

    // Called and returns at a falling edge.
    task automatic pulse_load();
        load_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offer stream_q byte by byte; gap_mod > 0 inserts random idle cycles.
    task automatic send_stream(input int gap_mod, input string tag);
        int idx;
        int budget;
        idx = 0;
        budget = stream_q.size() * 8 + 64;
        while (idx < stream_q.size() && budget > 0) begin
            if (gap_mod > 0 && $urandom_range(gap_mod - 1, 0) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = stream_q[idx];
            end
            if (byte_valid && byte_ready) idx++;
            @(negedge clk);
            budget--;
        end
        byte_valid = 1'b0;
        check({tag, "_bytes_sent"}, idx, stream_q.size());
    endtask

    task automatic wait_run(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            if (cpu_reset === 1'b0) begin
                when = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_write_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_write"}, wr_q[i], exp_q[i]);
            if (wr_q[i] !== exp_q[i]) break;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        run        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_cpu_reset",  cpu_reset,  1'b1);
        check("rst_byte_ready", byte_ready, 1'b0);
        check("rst_rom_we",     rom_we,     1'b0);
        check("rst_rom_addr",   rom_addr,   15'h0);
        check("rst_rom_wdata",  rom_wdata,  16'h0);
        check("rst_busy",       busy,       1'b0);
        check("rst_loaded",     loaded,     1'b0);
        check("rst_error",      error,      1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cpu_reset", cpu_reset, 1'b1);

        // run from IDLE releases the CPU without loading.
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("run_cpu_reset", cpu_reset, 1'b0);
        check("run_loaded",    loaded,    1'b0);
        check("run_busy",      busy,      1'b0);
        // load_start while running reasserts the CPU reset next cycle.
        pulse_load();
        check("run_restart_cpu_reset", cpu_reset, 1'b1);
        check("run_restart_busy",      busy,      1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fixed two-word load, no stalls: release exactly 10 cycles later.
        stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        exp_q.delete();
        exp_q.push_back({15'd0, 16'h1234});
        exp_q.push_back({15'd1, 16'hABCD});
        wr_q.delete();
        pulse_load();
        send_stream(0, "two");
        wait_run(20, at);
        check("two_latency", at - t0, 10);
        check("two_loaded",  loaded,  1'b1);
        check("two_busy",    busy,    1'b0);
        check_writes("two");

        // Random length, no stalls: latency 3N+4.
        n = $urandom_range(20, 3);
        make_load(n);
        wr_q.delete();
        pulse_load();
        send_stream(0, "rand_fast");
        wait_run(20, at);
        check("rand_fast_latency", at - t0, 3 * n + 4);
        check_writes("rand_fast");

        // Random length with random stalls.
        n = $urandom_range(40, 1);
        make_load(n);
        wr_q.delete();
        pulse_load();
        send_stream(3, "rand_gap");
        wait_run(20, at);
        check("rand_gap_released", at > 0, 1'b1);
        check("rand_gap_loaded",   loaded, 1'b1);
        check_writes("rand_gap");

        // Zero-length load: straight to RELEASE, then RUN.
        stream_q = '{8'h00, 8'h00};
        exp_q.delete();
        wr_q.delete();
        pulse_load();
        send_stream(0, "zero");
        check("zero_release_cpu_reset", cpu_reset, 1'b1);
        check("zero_release_busy",      busy,      1'b1);
        check("zero_release_loaded",    loaded,    1'b0);
        @(negedge clk);
        check("zero_run_cpu_reset", cpu_reset, 1'b0);
        check("zero_run_loaded",    loaded,    1'b1);
        check("zero_run_busy",      busy,      1'b0);
        check_writes("zero");

        // Oversized length 0x8001: rejected, CPU held, run ignored.
        stream_q = '{8'h80, 8'h01};
        exp_q.delete();
        wr_q.delete();
        pulse_load();
        send_stream(0, "err");
        check("err_error",      error,      1'b1);
        check("err_cpu_reset",  cpu_reset,  1'b1);
        check("err_busy",       busy,       1'b0);
        check("err_byte_ready", byte_ready, 1'b0);
        run = 1'b1;
        repeat (3) @(negedge clk);
        run = 1'b0;
        check("err_hold_error",     error,     1'b1);
        check("err_hold_cpu_reset", cpu_reset, 1'b1);
        check_writes("err");
        pulse_load();
        check("err_clear_error",      error,      1'b0);
        check("err_clear_busy",       busy,       1'b1);
        check("err_clear_byte_ready", byte_ready, 1'b1);

        // Restart mid-load after the first of three words.
        stream_q = '{8'h00, 8'h03, 8'h11, 8'h11};
        exp_q.delete();
        exp_q.push_back({15'd0, 16'h1111});
        exp_q.push_back({15'd0, 16'h5A5A});
        wr_q.delete();
        send_stream(0, "restart_a");
        @(negedge clk);
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h22;
        check("restart_busy_pulse", busy, 1'b1);
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b0;
        check("restart_busy_after", busy,       1'b1);
        check("restart_len_hi",     byte_ready, 1'b1);
        stream_q = '{8'h00, 8'h01, 8'h5A, 8'h5A};
        send_stream(0, "restart_b");
        wait_run(20, at);
        check("restart_released", at > 0, 1'b1);
        check_writes("restart");

        // Full-depth load with sparse random stalls.
        make_load(32768);
        wr_q.delete();
        pulse_load();
        send_stream(256, "full");
        wait_run(20, at);
        check("full_released", at > 0, 1'b1);
        check("full_loaded",   loaded, 1'b1);
        check_writes("full");
        repeat (10) @(negedge clk);
        check("full_no_extra_write", wr_q.size(), 32768);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
